// File: rtl/eth_rx_ctrl.sv
// Dibit receive controller: byte assembly, destination filter, payload FIFO and end-of-frame status.
// Define ETH_RX_CRC_EN to add FCS (CRC-32) checking of each frame.
module eth_rx_ctrl #(
    parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    input  logic        promisc,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    input  logic        m_ready,
    output logic        frame_ok,
    output logic        frame_bad,
    output logic        frame_drop,
    output logic [10:0] frame_len,
    output logic        overflow
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = 11;
    localparam logic [LW-1:0] LEN_MAX = '1;

    typedef enum logic [2:0] {
        S_WAIT_GAP, S_IDLE, S_DST, S_HDR, S_PAYLOAD, S_DROP
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    dib_cnt_q, dib_cnt_d;
    logic [5:0]    sh_q, sh_d;
    logic [3:0]    hdr_cnt_q, hdr_cnt_d;
    logic          dst_hit_q, dst_hit_d, dst_bc_q, dst_bc_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_v_q, hold_v_d;
    logic [LW-1:0] len_q, len_d;
    logic          err_q, err_d;
    logic          ok_q, ok_d, bad_q, bad_d, drop_q, drop_d;
    logic [LW-1:0] flen_q, flen_d;
    logic          ovf_q, ovf_d;

    logic [7:0]    byte_c, mac_byte_c;
    logic [5:0]    mac_sh_c;
    logic          byte_done_c, hit_c, bc_c, crc_ok_c;
    logic          push_c, push_last_c, push_ok_c, pop_c, accept_c;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    assign byte_c      = {axiid, sh_q};
    assign byte_done_c = axiiv && (dib_cnt_q == 2'd3);
    assign mac_sh_c    = 6'd40 - {hdr_cnt_q[2:0], 3'b000};
    assign mac_byte_c  = 8'(MAC_ADDR >> mac_sh_c);
    assign hit_c       = dst_hit_q && (byte_c == mac_byte_c);
    assign bc_c        = dst_bc_q && (byte_c == 8'hFF);

    assign m_valid   = (count_q != '0);
    assign m_data    = m_valid ? mem_q[rd_ptr_q][7:0] : 8'd0;
    assign m_last    = m_valid ? mem_q[rd_ptr_q][8] : 1'b0;
    assign pop_c     = m_valid && m_ready;
    assign accept_c  = (count_q != CW'(FIFO_DEPTH)) || pop_c;
    assign push_ok_c = push_c && accept_c;

`ifdef ETH_RX_CRC_EN
    localparam logic [31:0] CRC_POLY_REFL    = 32'hEDB8_8320;
    // Residue 0xC704DD7B as it appears in the bit-reflected shift register
    localparam logic [31:0] CRC_RESIDUE_REFL = 32'hDEBB_20E3;

    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (state_q == S_IDLE) begin
            crc_d = '1;
        end else if (byte_done_c && (state_q == S_DST || state_q == S_HDR || state_q == S_PAYLOAD)) begin
            crc_d = crc_step(crc_q, byte_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= '1;
        else        crc_q <= crc_d;
    end

    assign crc_ok_c = (crc_q == CRC_RESIDUE_REFL);
`else
    assign crc_ok_c = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_WAIT_GAP;
        else        state_q <= state_d;
    end

    // Next state, byte assembly, hold-one-byte payload push and status generation
    always_comb begin
        state_d     = state_q;
        dib_cnt_d   = dib_cnt_q;
        sh_d        = sh_q;
        hdr_cnt_d   = hdr_cnt_q;
        dst_hit_d   = dst_hit_q;
        dst_bc_d    = dst_bc_q;
        hold_d      = hold_q;
        hold_v_d    = hold_v_q;
        len_d       = len_q;
        err_d       = err_q;
        ok_d        = 1'b0;
        bad_d       = 1'b0;
        drop_d      = 1'b0;
        flen_d      = flen_q;
        ovf_d       = ovf_q;
        push_c      = 1'b0;
        push_last_c = 1'b0;

        if (!axiiv) begin
            dib_cnt_d = '0;
        end else if (state_q != S_WAIT_GAP) begin
            dib_cnt_d = dib_cnt_q + 2'd1;
            sh_d      = {axiid, sh_q[5:2]};
        end

        unique case (state_q)
            S_WAIT_GAP: if (!axiiv) state_d = S_IDLE;
            S_IDLE: begin
                hdr_cnt_d = '0;
                dst_hit_d = 1'b1;
                dst_bc_d  = 1'b1;
                hold_v_d  = 1'b0;
                len_d     = '0;
                err_d     = 1'b0;
                if (axiiv) state_d = S_DST;
            end
            S_DST: begin
                if (!axiiv) begin
                    bad_d   = 1'b1;
                    flen_d  = '0;
                    state_d = S_IDLE;
                end else if (byte_done_c) begin
                    dst_hit_d = hit_c;
                    dst_bc_d  = bc_c;
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (hdr_cnt_q == 4'd5) state_d = (hit_c || bc_c || promisc) ? S_HDR : S_DROP;
                end
            end
            S_HDR: begin
                if (!axiiv) begin
                    bad_d   = 1'b1;
                    flen_d  = '0;
                    state_d = S_IDLE;
                end else if (byte_done_c) begin
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (hdr_cnt_q == 4'd13) state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!axiiv) begin
                    push_c      = hold_v_q;
                    push_last_c = 1'b1;
                    flen_d      = len_q;
                    state_d     = S_IDLE;
                    if (hold_v_q && !accept_c) begin
                        ovf_d = 1'b1;
                        bad_d = 1'b1;
                    end else if (dib_cnt_q != 2'd0 || !crc_ok_c) begin
                        bad_d = 1'b1;
                    end else begin
                        ok_d = 1'b1;
                    end
                end else if (byte_done_c) begin
                    push_c = hold_v_q;
                    if (hold_v_q && !accept_c) begin
                        ovf_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_DROP;
                    end
                    hold_d   = byte_c;
                    hold_v_d = 1'b1;
                    if (len_q != LEN_MAX) len_d = len_q + LW'(1);
                end
            end
            S_DROP: begin
                if (!axiiv) begin
                    bad_d   = err_q;
                    drop_d  = !err_q;
                    flen_d  = len_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_WAIT_GAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dib_cnt_q <= '0;
            sh_q      <= '0;
            hdr_cnt_q <= '0;
            dst_hit_q <= 1'b1;
            dst_bc_q  <= 1'b1;
            hold_q    <= '0;
            hold_v_q  <= 1'b0;
            len_q     <= '0;
            err_q     <= 1'b0;
            ok_q      <= 1'b0;
            bad_q     <= 1'b0;
            drop_q    <= 1'b0;
            flen_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            dib_cnt_q <= dib_cnt_d;
            sh_q      <= sh_d;
            hdr_cnt_q <= hdr_cnt_d;
            dst_hit_q <= dst_hit_d;
            dst_bc_q  <= dst_bc_d;
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
            len_q     <= len_d;
            err_q     <= err_d;
            ok_q      <= ok_d;
            bad_q     <= bad_d;
            drop_q    <= drop_d;
            flen_q    <= flen_d;
            ovf_q     <= ovf_d;
        end
    end

    assign frame_ok   = ok_q;
    assign frame_bad  = bad_q;
    assign frame_drop = drop_q;
    assign frame_len  = flen_q;
    assign overflow   = ovf_q;

    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= {push_last_c, hold_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)     rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_ok_c) - CW'(pop_c);
        end
    end

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Self-checking bench for eth_rx_ctrl: vector table, corner sequences and randomized frames vs. a frame-level model.
module tb_eth_rx_ctrl;
    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_09;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        axiiv = 1'b0;
    logic [1:0]  axiid = 2'd0;
    logic        promisc = 1'b0;
    logic        m_ready = 1'b1;
    logic        m_valid, m_last, frame_ok, frame_bad, frame_drop, overflow;
    logic [7:0]  m_data;
    logic [10:0] frame_len;

    always #5 clk = ~clk;

    eth_rx_ctrl #(.MAC_ADDR(MAC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid), .promisc(promisc),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .frame_ok(frame_ok), .frame_bad(frame_bad), .frame_drop(frame_drop),
        .frame_len(frame_len), .overflow(overflow)
    );

    typedef struct packed {
        logic        ok;
        logic        bad;
        logic        drop;
        logic [10:0] len;
    } stat_t;

    typedef struct {
        int dst_sel;
        int prom;
        int nb;
        int extra;
        int fix;
        int e_ok;
        int e_bad;
        int e_drop;
        int e_len;
        int e_nbytes;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         ready_mode = 1;
    stat_t      stat_q[$];
    logic [8:0] rx_q[$];
    logic [7:0] frm[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) rx_q.push_back({m_last, m_data});
            if (frame_ok || frame_bad || frame_drop) begin
                stat_q.push_back({frame_ok, frame_bad, frame_drop, frame_len});
                checks++;
                if (int'(frame_ok) + int'(frame_bad) + int'(frame_drop) != 1) begin
                    errors++;
                    $display("FAIL pulse_exclusive: ok=%0b bad=%0b drop=%0b", frame_ok, frame_bad, frame_drop);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] d);
        @(posedge clk);
        #1;
        axiiv = v;
        axiid = d;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(3) != 0);
        endcase
    endtask

    task automatic send_bytes(input int lo, input int hi);
        logic [7:0] b;
        for (int i = lo; i < hi; i++) begin
            b = frm[i];
            for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
        end
    endtask

    task automatic send_extra(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 2'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0);
    endtask

    task automatic wait_done();
        int n;
        idle(3);
        n = 0;
        while (m_valid && n < 400) begin
            drive(1'b0, 2'd0);
            n++;
        end
        if (m_valid) check("drain_timeout", 1, 0);
        idle(2);
    endtask

    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input int dst_sel, input int nb, input int fix, input int rnd);
        logic [47:0] d;
        logic [31:0] c;
        d = (dst_sel == 0) ? MAC : (dst_sel == 1) ? 48'hFFFF_FFFF_FFFF : OTHER;
        frm.delete();
        for (int i = 0; i < nb; i++) begin
            if (i < 6)        frm.push_back(d[8*(5-i) +: 8]);
            else if (i < 12)  frm.push_back(8'(8'hA0 + i));
            else if (i == 12) frm.push_back(8'h08);
            else if (i == 13) frm.push_back(8'h00);
            else              frm.push_back((rnd != 0) ? 8'($urandom) : 8'(i - 14));
        end
        if (fix != 0 && nb >= 14) begin
            c = crc32(nb - 4);
            for (int k = 0; k < 4; k++) frm[nb-4+k] = c[8*k +: 8];
        end
    endtask

    function automatic bit fcs_good(input int nb);
`ifdef ETH_RX_CRC_EN
        return crc32(nb - 4) == {frm[nb-1], frm[nb-2], frm[nb-3], frm[nb-4]};
`else
        return (nb >= 0);
`endif
    endfunction

    // Frame-level reference: whole-frame view of filter, runt, partial-byte and FCS rules
    task automatic model(input int nb, input int extra, input bit prom, output stat_t s, output int npay);
        bit is_mac, is_bc;
        logic [47:0] m;
        m = MAC;
        s = '0;
        npay = 0;
        is_mac = 1'b1;
        is_bc = 1'b1;
        for (int i = 0; i < 6 && i < nb; i++) begin
            if (frm[i] != m[8*(5-i) +: 8]) is_mac = 1'b0;
            if (frm[i] != 8'hFF) is_bc = 1'b0;
        end
        if (nb >= 6 && !(is_mac || is_bc || prom)) begin
            s.drop = 1'b1;
        end else if (nb < 14) begin
            s.bad = 1'b1;
        end else begin
            npay = nb - 14;
            s.len = (npay > 2047) ? 11'd2047 : 11'(npay);
            if (extra % 4 != 0 || !fcs_good(nb)) s.bad = 1'b1;
            else s.ok = 1'b1;
        end
    endtask

    task automatic expect_frame(input string nm, input stat_t es, input int npay);
        int bad_bytes;
        logic [8:0] e;
        check({nm, "_npulse"}, stat_q.size(), 1);
        if (stat_q.size() > 0) check({nm, "_status"}, int'(stat_q[0]), int'(es));
        check({nm, "_nbytes"}, rx_q.size(), npay);
        bad_bytes = 0;
        for (int i = 0; i < rx_q.size() && i < npay; i++) begin
            e = {(i == npay - 1), frm[14+i]};
            if (rx_q[i] != e) bad_bytes++;
        end
        check({nm, "_data"}, bad_bytes, 0);
        stat_q.delete();
        rx_q.delete();
    endtask

    task automatic run_frame(input int nb, input int extra, input bit prom);
        promisc = prom;
        send_bytes(0, nb);
        send_extra(extra);
        wait_done();
    endtask

    vec_t  tbl[10];
    stat_t es;
    int    npay;
    int    nlast;

    initial begin
        tbl[0] = '{0, 0, 60, 0, 1, 1, 0, 0, 46, 46};
        tbl[1] = '{2, 0, 60, 0, 0, 0, 0, 1,  0,  0};
        tbl[2] = '{2, 1, 60, 0, 1, 1, 0, 0, 46, 46};
        tbl[3] = '{1, 0, 18, 2, 0, 0, 1, 0,  4,  4};
        tbl[4] = '{0, 0, 14, 0, 1, 1, 0, 0,  0,  0};
        tbl[5] = '{0, 0, 10, 0, 0, 0, 1, 0,  0,  0};
        tbl[6] = '{0, 0,  3, 1, 0, 0, 1, 0,  0,  0};
        tbl[7] = '{2, 0,  8, 0, 0, 0, 0, 1,  0,  0};
        tbl[8] = '{0, 0, 14, 2, 0, 0, 1, 0,  0,  0};
        tbl[9] = '{1, 0, 20, 0, 1, 1, 0, 0,  6,  6};

        #22;
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_pulses", int'({frame_ok, frame_bad, frame_drop}), 0);
        check("rst_frame_len", int'(frame_len), 0);
        check("rst_overflow", int'(overflow), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        for (int t = 0; t < 10; t++) begin
            build(tbl[t].dst_sel, tbl[t].nb, tbl[t].fix, 0);
            run_frame(tbl[t].nb, tbl[t].extra, tbl[t].prom != 0);
            es = {tbl[t].e_ok != 0, tbl[t].e_bad != 0, tbl[t].e_drop != 0, 11'(tbl[t].e_len)};
            expect_frame($sformatf("tbl%0d", t), es, tbl[t].e_nbytes);
        end

        // Corrupted payload bit: only an FCS-checking build flags it
        build(0, 60, 1, 0);
        frm[20] = frm[20] ^ 8'h04;
        run_frame(60, 0, 1'b0);
`ifdef ETH_RX_CRC_EN
        es = {1'b0, 1'b1, 1'b0, 11'd46};
`else
        es = {1'b1, 1'b0, 1'b0, 11'd46};
`endif
        expect_frame("crc_flip", es, 46);

        // Backpressure overflow: 16 entries kept, frame reported bad
        ready_mode = 0;
        build(0, 54, 0, 0);
        promisc = 1'b0;
        send_bytes(0, 54);
        idle(4);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_npulse", stat_q.size(), 1);
        if (stat_q.size() > 0) check("ovf_status", int'({stat_q[0].ok, stat_q[0].bad, stat_q[0].drop}), 2);
        check("ovf_m_valid", int'(m_valid), 1);
        ready_mode = 1;
        wait_done();
        check("ovf_nbytes", rx_q.size(), 16);
        nlast = 0;
        npay = 0;
        for (int i = 0; i < rx_q.size(); i++) begin
            if (rx_q[i][8]) nlast++;
            if (i < 16 && rx_q[i][7:0] != frm[14+i]) npay++;
        end
        check("ovf_no_last", nlast, 0);
        check("ovf_data", npay, 0);
        stat_q.delete();
        rx_q.delete();

        // Reset mid-payload, released while the frame is still arriving
        build(0, 60, 1, 0);
        send_bytes(0, 30);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_overflow", int'(overflow), 0);
        check("midrst_frame_len", int'(frame_len), 0);
        check("midrst_pulses", int'({frame_ok, frame_bad, frame_drop}), 0);
        rx_q.delete();
        stat_q.delete();
        send_bytes(30, 32);
        rst_n = 1'b1;
        send_bytes(32, 44);
        wait_done();
        check("midrst_no_pulse", stat_q.size(), 0);
        check("midrst_no_bytes", rx_q.size(), 0);
        stat_q.delete();
        rx_q.delete();
        build(0, 60, 1, 0);
        run_frame(60, 0, 1'b0);
        expect_frame("after_rst", {1'b1, 1'b0, 1'b0, 11'd46}, 46);

        // Length counter saturation
        build(0, 14 + 2060, 1, 0);
        run_frame(14 + 2060, 0, 1'b0);
        expect_frame("len_sat", {1'b1, 1'b0, 1'b0, 11'd2047}, 2060);

        ready_mode = 2;
        for (int r = 0; r < 40; r++) begin
            int sel, nb, extra, fix;
            bit prom;
            sel   = int'($urandom_range(2));
            nb    = int'($urandom_range(70, 1));
            extra = ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
            fix   = int'($urandom_range(1));
            prom  = ($urandom_range(3) == 0);
            build(sel, nb, fix, 1);
            model(nb, extra, prom, es, npay);
            run_frame(nb, extra, prom);
            expect_frame($sformatf("rnd%0d", r), es, npay);
        end
        check("rnd_no_overflow", int'(overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_rx_ctrl.md
ETH_RX_CTRL -- requirements
Module: eth_rx_ctrl

Interface
REQ-001 SHALL have parameter MAC_ADDR, default 48'h02_00_00_00_00_01, station address; first wire byte = MAC_ADDR[47:40].
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries (power of 2, >=4).
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port axiiv  in  1  dibit valid from preamble stripper, one dibit per cycle while high.
REQ-006 SHALL have port axiid  in  2  dibit data; first dibit of each byte = bits [1:0].
REQ-007 SHALL have port promisc  in  1  1 = accept any destination address.
REQ-008 SHALL have ports m_valid/m_data/m_last  out  1/8/1  payload byte stream, m_last on final frame byte.
REQ-009 SHALL have port m_ready  in  1  downstream accept.
REQ-010 SHALL have ports frame_ok/frame_bad/frame_drop  out  1 each  one-cycle end-of-frame status pulses, mutually exclusive.
REQ-011 SHALL have port frame_len  out  11  payload byte count, valid with any status pulse, saturates at 2047.
REQ-012 SHALL have port overflow  out  1  sticky FIFO overflow flag.

Function
REQ-013 SHALL assemble bytes from 4 consecutive valid dibits, LSB dibit first.
REQ-014 SHALL sequence states WAIT_GAP -> IDLE -> DST (6 bytes) -> HDR (8 bytes: src+type) -> PAYLOAD -> IDLE; DROP on filter miss or overflow.
REQ-015 SHALL leave WAIT_GAP only after sampling axiiv=0; IDLE -> DST on axiiv=1.
REQ-016 SHALL, at end of DST, enter HDR if dst==MAC_ADDR, dst==FF:FF:FF:FF:FF:FF, or promisc=1; otherwise DROP.
REQ-017 SHALL forward only bytes after the 14-byte header, FCS bytes included, counted in frame_len.
REQ-018 SHALL hold each payload byte one byte-time, pushing it with last=0 when the next byte completes, or with last=1 in the cycle after axiiv falls.
REQ-019 SHALL detect frame end as axiiv 1->0; status pulse asserted the cycle after first axiiv=0 sample.
REQ-020 SHALL pulse frame_ok on end in PAYLOAD/HDR-complete with dibit count multiple of 4 and no error; zero-payload frame gives frame_ok, frame_len=0, no push.
REQ-021 SHALL pulse frame_bad on end before 14 header bytes (runt), partial trailing byte (partial byte discarded, held byte still pushed with last=1), or overflow during the frame.
REQ-022 SHALL pulse frame_drop on end in DROP caused by filter miss; no bytes pushed for that frame.
REQ-023 SHALL implement FIFO of {last,data}, show-ahead: m_valid = not empty, m_data/m_last = head entry; pop on m_valid&&m_ready.
REQ-024 SHALL accept a push when count<FIFO_DEPTH or a pop occurs the same cycle.
REQ-025 SHALL, on rejected push, set overflow, enter DROP for remainder of frame, and end it with frame_bad; already-queued bytes remain.

Reset
REQ-026 SHALL on rst_n=0 immediately clear: state=WAIT_GAP, FIFO empty, m_valid=0, m_data=0, m_last=0, status pulses 0, frame_len=0, overflow=0, byte/dibit counters 0.
REQ-027 SHALL discard any frame in progress at reset; a frame active at reset release is ignored until axiiv=0.

Configuration
REQ-028 SHALL, with ETH_RX_CRC_EN defined, compute reflected CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF) over all bytes from DST through FCS and pulse frame_bad instead of frame_ok if residue != 0xC704DD7B.
REQ-029 SHALL, without ETH_RX_CRC_EN, contain no CRC logic and never flag CRC errors.

Verification
REQ-030 Frame dst=MAC_ADDR, 14 hdr + 46 payload bytes 0x00..0x2D, m_ready=1 -> 46 bytes in order, m_last on 0x2D, frame_ok, frame_len=46.
REQ-031 Same frame dst=02:00:00:00:00:09, promisc=0 -> no m_valid, frame_drop, frame_len=0; promisc=1 -> delivered, frame_ok.
REQ-032 Broadcast dst, payload 4 bytes plus 2 extra dibits -> 4 bytes, last on 4th, frame_bad, frame_len=4.
REQ-033 m_ready=0, 40-byte payload, FIFO_DEPTH=16 -> 16 bytes queued, overflow=1, frame_bad; after m_ready=1 exactly 16 bytes drain, none with last.
REQ-034 rst_n low mid-payload, released with axiiv=1 -> FIFO empty, no status pulse; next full frame after gap -> frame_ok.
REQ-035 With ETH_RX_CRC_EN: valid 60-byte frame with correct FCS -> frame_ok; one payload bit flipped -> frame_bad, bytes still delivered.
